// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and types for the register-file scoreboard.
package rf_scoreboard_pkg;

    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned MAX_OUT    = 4;
    localparam int unsigned OUT_W      = $clog2(MAX_OUT + 1);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      pend_cnt_t;
    typedef logic [OUT_W-1:0]      out_cnt_t;

    // Largest value a per-register pending counter may hold.
    localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/rf_scoreboard_entry.sv
// Pending-write counter for a single architectural register.
module rf_scoreboard_entry
    import rf_scoreboard_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_inc,
    input  logic      i_dec,
    input  logic      i_clr,
    output pend_cnt_t o_cnt,
    output logic      o_busy,
    output logic      o_at_max
);

    pend_cnt_t r_cnt;
    pend_cnt_t w_cnt_next;

    // Next count: clear wins, simultaneous inc/dec cancel out.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (i_inc && !i_dec) begin
            w_cnt_next = r_cnt + pend_cnt_t'(1);
        end else if (i_dec && !i_inc) begin
            w_cnt_next = r_cnt - pend_cnt_t'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_busy   = (r_cnt != '0);
    assign o_at_max = (r_cnt == PEND_MAX);

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard between issue and write-back.
// Optional macro RF_SCOREBOARD_WB_BYPASS_EN: a same-cycle retire clears a
// last-pending RAW hazard and the full condition.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_issue_valid,
    output logic            o_issue_ready,
    input  logic            i_issue_rs1_ren,
    input  reg_addr_t       i_issue_rs1_addr,
    input  logic            i_issue_rs2_ren,
    input  reg_addr_t       i_issue_rs2_addr,
    input  logic            i_issue_rd_wen,
    input  reg_addr_t       i_issue_rd_addr,
    input  logic            i_wb_valid,
    input  reg_addr_t       i_wb_rd_addr,
    input  logic            i_flush,
    output logic [NREG-1:0] o_busy_vec,
    output out_cnt_t        o_out_cnt,
    output logic            o_err
);

    pend_cnt_t w_pend   [NREG];
    logic      w_at_max [NREG];
    logic      w_busy   [NREG];

    logic      w_issue_fire;
    logic      w_track;
    logic      w_wb_nz;
    logic      w_wb_eff;
    logic      w_raw1;
    logic      w_raw2;
    logic      w_waw;
    logic      w_full;
    out_cnt_t  r_out_cnt;
    out_cnt_t  w_out_cnt_next;
    logic      r_err;

    // x0 is never tracked.
    assign w_pend[0]   = '0;
    assign w_at_max[0] = 1'b0;
    assign w_busy[0]   = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        rf_scoreboard_entry u_entry (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_inc    (w_track && (i_issue_rd_addr == reg_addr_t'(g))),
            .i_dec    (w_wb_eff && (i_wb_rd_addr == reg_addr_t'(g))),
            .i_clr    (i_flush),
            .o_cnt    (w_pend[g]),
            .o_busy   (w_busy[g]),
            .o_at_max (w_at_max[g])
        );
    end

    for (genvar g = 0; g < NREG; g++) begin : g_busy
        assign o_busy_vec[g] = w_busy[g];
    end

    assign w_wb_nz  = i_wb_valid && (i_wb_rd_addr != '0);
    assign w_wb_eff = w_wb_nz && (w_pend[i_wb_rd_addr] != '0);

    // Hazard and budget evaluation for the current issue request.
    always_comb begin
        w_raw1 = i_issue_rs1_ren && (i_issue_rs1_addr != '0) &&
                 (w_pend[i_issue_rs1_addr] != '0);
        w_raw2 = i_issue_rs2_ren && (i_issue_rs2_addr != '0) &&
                 (w_pend[i_issue_rs2_addr] != '0);
        w_waw  = i_issue_rd_wen && (i_issue_rd_addr != '0) && w_at_max[i_issue_rd_addr];
        w_full = (r_out_cnt == out_cnt_t'(MAX_OUT));
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
        // Retiring the last pending write forwards its data to the read ports.
        if (w_wb_eff && (i_wb_rd_addr == i_issue_rs1_addr) &&
            (w_pend[i_issue_rs1_addr] == pend_cnt_t'(1))) begin
            w_raw1 = 1'b0;
        end
        if (w_wb_eff && (i_wb_rd_addr == i_issue_rs2_addr) &&
            (w_pend[i_issue_rs2_addr] == pend_cnt_t'(1))) begin
            w_raw2 = 1'b0;
        end
        if (w_wb_eff) begin
            w_full = 1'b0;
        end
`endif
    end

    assign o_issue_ready = !(w_raw1 || w_raw2 || w_waw || w_full || i_flush);
    assign w_issue_fire  = i_issue_valid && o_issue_ready;
    assign w_track       = w_issue_fire && i_issue_rd_wen && (i_issue_rd_addr != '0);

    // In-flight total: same cancel rule as the per-register counters.
    always_comb begin
        w_out_cnt_next = r_out_cnt;
        if (i_flush) begin
            w_out_cnt_next = '0;
        end else if (w_track && !w_wb_eff) begin
            w_out_cnt_next = r_out_cnt + out_cnt_t'(1);
        end else if (w_wb_eff && !w_track) begin
            w_out_cnt_next = r_out_cnt - out_cnt_t'(1);
        end
    end

    // In-flight counter and sticky retire-without-pending error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_out_cnt <= w_out_cnt_next;
            if (w_wb_nz && !w_wb_eff) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_out_cnt = r_out_cnt;
    assign o_err     = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;
    import rf_scoreboard_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            issue_valid;
    logic            issue_ready;
    logic            rs1_ren;
    reg_addr_t       rs1_addr;
    logic            rs2_ren;
    reg_addr_t       rs2_addr;
    logic            rd_wen;
    reg_addr_t       rd_addr;
    logic            wb_valid;
    reg_addr_t       wb_rd_addr;
    logic            flush;
    logic [NREG-1:0] busy_vec;
    out_cnt_t        out_cnt;
    logic            err;

    int n_total;
    int n_bad;

    rf_scoreboard dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_issue_valid    (issue_valid),
        .o_issue_ready    (issue_ready),
        .i_issue_rs1_ren  (rs1_ren),
        .i_issue_rs1_addr (rs1_addr),
        .i_issue_rs2_ren  (rs2_ren),
        .i_issue_rs2_addr (rs2_addr),
        .i_issue_rd_wen   (rd_wen),
        .i_issue_rd_addr  (rd_addr),
        .i_wb_valid       (wb_valid),
        .i_wb_rd_addr     (wb_rd_addr),
        .i_flush          (flush),
        .o_busy_vec       (busy_vec),
        .o_out_cnt        (out_cnt),
        .o_err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        rs1_ren     = 1'b0;
        rs1_addr    = '0;
        rs2_ren     = 1'b0;
        rs2_addr    = '0;
        rd_wen      = 1'b0;
        rd_addr     = '0;
        wb_valid    = 1'b0;
        wb_rd_addr  = '0;
        flush       = 1'b0;
    endtask

    // Apply current inputs across one edge, then return to idle.
    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic issue_wr(input int rd);
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = reg_addr_t'(rd);
        #1;
        check($sformatf("ready_issue_rd%0d", rd), 32'(issue_ready), 32'd1);
        cycle();
    endtask

    task automatic retire(input int rd);
        wb_valid   = 1'b1;
        wb_rd_addr = reg_addr_t'(rd);
        cycle();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle();
        rst_n = 1'b0;
        #12;
        check("rst_busy", 32'(busy_vec), 32'h0);
        check("rst_out", 32'(out_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_valid = 1'b1;
        #1;
        check("rst_ready", 32'(issue_ready), 32'd1);
        idle();

        // RAW on rd=5, then retire (optionally bypassed same cycle).
        issue_wr(5);
        issue_valid = 1'b1;
        rs1_ren     = 1'b1;
        rs1_addr    = 5'd5;
        #1;
        check("raw_ready", 32'(issue_ready), 32'd0);
        check("raw_busy5", 32'(busy_vec[5]), 32'd1);
        check("raw_out", 32'(out_cnt), 32'd1);
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd5;
        #1;
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
        check("bypass_ready", 32'(issue_ready), 32'd1);
`else
        check("bypass_ready", 32'(issue_ready), 32'd0);
`endif
        cycle();
        issue_valid = 1'b1;
        rs1_ren     = 1'b1;
        rs1_addr    = 5'd5;
        #1;
        check("after_wb_ready", 32'(issue_ready), 32'd1);
        check("after_wb_busy", 32'(busy_vec), 32'h0);
        check("after_wb_out", 32'(out_cnt), 32'd0);
        cycle();

        // WAW saturation on rd=7.
        for (int i = 0; i < 3; i++) issue_wr(7);
        check("waw_out", 32'(out_cnt), 32'd3);
        check("waw_busy", 32'(busy_vec), 32'h80);
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = 5'd7;
        #1;
        check("waw_ready", 32'(issue_ready), 32'd0);
        idle();
        retire(7);
        retire(7);
        check("waw_busy_2wb", 32'(busy_vec), 32'h80);
        check("waw_out_2wb", 32'(out_cnt), 32'd1);
        retire(7);
        check("waw_busy_3wb", 32'(busy_vec), 32'h0);
        check("waw_out_3wb", 32'(out_cnt), 32'd0);

        // Full in-flight budget.
        for (int r = 1; r <= 4; r++) issue_wr(r);
        check("full_out", 32'(out_cnt), 32'd4);
        check("full_busy", 32'(busy_vec), 32'h1E);
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = 5'd9;
        #1;
        check("full_ready", 32'(issue_ready), 32'd0);
        idle();
        retire(2);
        check("full_out_wb", 32'(out_cnt), 32'd3);
        check("full_busy_wb", 32'(busy_vec), 32'h1A);
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = 5'd9;
        #1;
        check("full_ready_wb", 32'(issue_ready), 32'd1);
        idle();

        // Same-cycle issue and retire on rd=3 cancel out.
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = 5'd3;
        wb_valid    = 1'b1;
        wb_rd_addr  = 5'd3;
        #1;
        check("same_ready", 32'(issue_ready), 32'd1);
        cycle();
        check("same_out", 32'(out_cnt), 32'd3);
        check("same_busy", 32'(busy_vec), 32'h1A);

        // x0 traffic is ignored.
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = 5'd0;
        wb_valid    = 1'b1;
        wb_rd_addr  = 5'd0;
        cycle();
        check("x0_out", 32'(out_cnt), 32'd3);
        check("x0_busy", 32'(busy_vec), 32'h1A);
        check("x0_err", 32'(err), 32'd0);

        // Flush with a pending issue.
        issue_valid = 1'b1;
        rd_wen      = 1'b1;
        rd_addr     = 5'd10;
        flush       = 1'b1;
        #1;
        check("flush_ready", 32'(issue_ready), 32'd0);
        cycle();
        check("flush_busy", 32'(busy_vec), 32'h0);
        check("flush_out", 32'(out_cnt), 32'd0);

        // Retire without pending sets sticky err.
        retire(6);
        check("err_set", 32'(err), 32'd1);
        check("err_nochg", 32'(out_cnt), 32'd0);
        flush = 1'b1;
        cycle();
        check("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-operation.
        issue_wr(12);
        check("pre_rst_out", 32'(out_cnt), 32'd1);
        rst_n = 1'b0;
        #2;
        check("async_rst_out", 32'(out_cnt), 32'd0);
        check("async_rst_busy", 32'(busy_vec), 32'h0);
        check("async_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_valid = 1'b1;
        rs1_ren     = 1'b1;
        rs1_addr    = 5'd12;
        #1;
        check("post_rst_ready", 32'(issue_ready), 32'd1);
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
